// File: rtl/demux1ne4_pkg.sv
// ----------------------------------------------------------------------------
// demux1ne4_pkg
//   Shared definitions for the 1-to-4 buffered demultiplexer.
//   Contents:
//     DEFAULT_WIDTH  default data word width (CPU word, 24 bits)
//     NUM_OUT        number of output slots (4)
//     SEL_W          width of the destination select (2)
//     slot_st_t      per-slot state encoding (EMPTY / FULL)
//     sel_onehot()   decode a destination select into a one-hot slot vector
// ----------------------------------------------------------------------------
package demux1ne4_pkg;

    localparam int DEFAULT_WIDTH = 24;
    localparam int NUM_OUT       = 4;
    localparam int SEL_W         = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_st_t;

    function automatic logic [NUM_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage : demux1ne4_pkg

// File: rtl/demux1ne4_buf_slot.sv
// ----------------------------------------------------------------------------
// demux_slot
//   One-entry holding buffer for a single demultiplexer output.
//   The slot is EMPTY or FULL; FULL means out_data carries a word the sink
//   has not yet taken. A load while FULL is only issued by the parent when
//   the sink drains in the same cycle, giving bubble-free pass-through.
//
//   Optional feature (macro DEMUX1NE4_STATS_EN): saturating counter of
//   completed output transfers, cleared only by reset.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   load       in   1      accept load_data into this slot this cycle
//   load_data  in   WIDTH  word to capture on load
//   out_ready  in   1      sink takes the held word this cycle
//   out_data   out  WIDTH  held word (stable while FULL and not taken)
//   state      out  enum   current slot state; FULL is the output valid
//   count      out  CNT_W  completed transfers (DEMUX1NE4_STATS_EN only)
// ----------------------------------------------------------------------------
module demux_slot
    import demux1ne4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX1NE4_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output slot_st_t         state
`ifdef DEMUX1NE4_STATS_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    slot_st_t         state_q;
    slot_st_t         state_d;
    logic [WIDTH-1:0] data_q;
    logic             drain;

    // A ready sink on an EMPTY slot is ignored: drain needs a held word.
    assign drain = (state_q == FULL) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // Drain together with load keeps the slot FULL with the new word.
                if (drain && !load) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Data only moves on load; while EMPTY it keeps the last delivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign out_data = data_q;
    assign state    = state_q;

`ifdef DEMUX1NE4_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating: once all ones, further drains leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (drain && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count = cnt_q;
`endif

endmodule : demux_slot

// File: rtl/demux1ne4_buf.sv
// ----------------------------------------------------------------------------
// demux1ne4_buf
//   1-to-4 buffered demultiplexer. A single producer offers a word together
//   with a destination select S; the word is captured into the one-entry
//   slot of output S and presented on Dalja<S> one clock later. Each output
//   stalls independently, so a blocked sink never holds up other selects.
//
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid and ready are both 1. The offerer keeps data/select stable while
//   valid is 1 and ready is 0; ready never depends on the same side's valid.
//   HyrjaReady = slot S is empty, or its sink is taking the held word now.
//
//   Optional feature (macro DEMUX1NE4_STATS_EN): adds parameter CNT_W and
//   ports Numeruesi0..3, saturating per-output transfer counters.
//
// Ports:
//   Clock          in   1      rising-edge clock
//   Resetn         in   1      asynchronous active-low reset
//   Hyrja          in   WIDTH  input word
//   S              in   2      destination select (0..3)
//   HyrjaValid     in   1      producer offers Hyrja/S this cycle
//   HyrjaReady     out  1      block accepts the offer this cycle
//   Dalja0..3      out  WIDTH  per-output held word
//   DaljaValid     out  4      bit i: Dalja<i> holds a valid word
//   DaljaReady     in   4      bit i: sink i takes its word this cycle
//   Numeruesi0..3  out  CNT_W  per-output transfer count (stats build only)
// ----------------------------------------------------------------------------
module demux1ne4_buf
    import demux1ne4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX1NE4_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [WIDTH-1:0]   Hyrja,
    input  logic [SEL_W-1:0]   S,
    input  logic               HyrjaValid,
    output logic               HyrjaReady,
    output logic [WIDTH-1:0]   Dalja0,
    output logic [WIDTH-1:0]   Dalja1,
    output logic [WIDTH-1:0]   Dalja2,
    output logic [WIDTH-1:0]   Dalja3,
    output logic [NUM_OUT-1:0] DaljaValid,
    input  logic [NUM_OUT-1:0] DaljaReady
`ifdef DEMUX1NE4_STATS_EN
    ,
    output logic [CNT_W-1:0]   Numeruesi0,
    output logic [CNT_W-1:0]   Numeruesi1,
    output logic [CNT_W-1:0]   Numeruesi2,
    output logic [CNT_W-1:0]   Numeruesi3
`endif
);

    logic [WIDTH-1:0]   slot_data [NUM_OUT];
    slot_st_t           slot_st   [NUM_OUT];
    logic [NUM_OUT-1:0] slot_load;
    logic               acc;

`ifdef DEMUX1NE4_STATS_EN
    logic [CNT_W-1:0]   slot_cnt  [NUM_OUT];
`endif

    // Readiness looks only at the selected slot; other slots may be stalled.
    assign HyrjaReady = !DaljaValid[S] || DaljaReady[S];
    assign acc        = HyrjaValid && HyrjaReady;
    assign slot_load  = sel_onehot(S) & {NUM_OUT{acc}};

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
`ifdef DEMUX1NE4_STATS_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_slot (
            .clk       (Clock),
            .rst_n     (Resetn),
            .load      (slot_load[i]),
            .load_data (Hyrja),
            .out_ready (DaljaReady[i]),
            .out_data  (slot_data[i]),
            .state     (slot_st[i])
`ifdef DEMUX1NE4_STATS_EN
            ,
            .count     (slot_cnt[i])
`endif
        );

        assign DaljaValid[i] = (slot_st[i] == FULL);
    end

    assign Dalja0 = slot_data[0];
    assign Dalja1 = slot_data[1];
    assign Dalja2 = slot_data[2];
    assign Dalja3 = slot_data[3];

`ifdef DEMUX1NE4_STATS_EN
    assign Numeruesi0 = slot_cnt[0];
    assign Numeruesi1 = slot_cnt[1];
    assign Numeruesi2 = slot_cnt[2];
    assign Numeruesi3 = slot_cnt[3];
`endif

endmodule : demux1ne4_buf

// File: tb/tb_demux1ne4_buf.sv
// ----------------------------------------------------------------------------
// tb_demux1ne4_buf
//   Directed and random checks of the 1-to-4 buffered demultiplexer.
//   With DEMUX1NE4_STATS_EN defined the DUT is built with CNT_W=4 and the
//   saturating counters are exercised as well.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux1ne4_buf;

    localparam int W = 24;

    // ---------------- clock / reset / DUT ----------------
    logic         Clock = 1'b0;
    logic         Resetn;
    logic [W-1:0] Hyrja;
    logic [1:0]   S;
    logic         HyrjaValid;
    logic         HyrjaReady;
    logic [W-1:0] Dalja0, Dalja1, Dalja2, Dalja3;
    logic [3:0]   DaljaValid;
    logic [3:0]   DaljaReady;
`ifdef DEMUX1NE4_STATS_EN
    logic [3:0]   Numeruesi0, Numeruesi1, Numeruesi2, Numeruesi3;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q[4][$];

    always #5 Clock = ~Clock;

    demux1ne4_buf #(
        .WIDTH (W)
`ifdef DEMUX1NE4_STATS_EN
        ,
        .CNT_W (4)
`endif
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Hyrja      (Hyrja),
        .S          (S),
        .HyrjaValid (HyrjaValid),
        .HyrjaReady (HyrjaReady),
        .Dalja0     (Dalja0),
        .Dalja1     (Dalja1),
        .Dalja2     (Dalja2),
        .Dalja3     (Dalja3),
        .DaljaValid (DaljaValid),
        .DaljaReady (DaljaReady)
`ifdef DEMUX1NE4_STATS_EN
        ,
        .Numeruesi0 (Numeruesi0),
        .Numeruesi1 (Numeruesi1),
        .Numeruesi2 (Numeruesi2),
        .Numeruesi3 (Numeruesi3)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn     = 1'b0;
        Hyrja      = '0;
        S          = '0;
        HyrjaValid = 1'b0;
        DaljaReady = '0;
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
    endtask

    function automatic logic [W-1:0] dalja_of(input int i);
        case (i)
            0:       return Dalja0;
            1:       return Dalja1;
            2:       return Dalja2;
            default: return Dalja3;
        endcase
    endfunction

    // ---------------- test: reset ----------------
    task automatic test_reset();
        do_reset();
        n_total++; if (DaljaValid !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", DaljaValid); else n_pass++;
        n_total++; if ({Dalja0, Dalja1, Dalja2, Dalja3} !== '0) $display("FAIL rst_data: got %h %h %h %h want 0", Dalja0, Dalja1, Dalja2, Dalja3); else n_pass++;
        n_total++; if (HyrjaReady !== 1'b1) $display("FAIL rst_ready: got %b want 1", HyrjaReady); else n_pass++;
        // fill slot 2, then assert reset mid-run
        S = 2'd2; Hyrja = 24'h123456; HyrjaValid = 1'b1;
        tick();
        HyrjaValid = 1'b0;
        n_total++; if (DaljaValid !== 4'b0100) $display("FAIL rst_fill_valid: got %b want 0100", DaljaValid); else n_pass++;
        n_total++; if (Dalja2 !== 24'h123456) $display("FAIL rst_fill_data: got %h want 123456", Dalja2); else n_pass++;
        tick();
        Resetn = 1'b0;
        #1;
        n_total++; if (DaljaValid !== 4'b0000) $display("FAIL rst_async_valid: got %b want 0000", DaljaValid); else n_pass++;
        n_total++; if (Dalja2 !== 24'h000000) $display("FAIL rst_async_data: got %h want 000000", Dalja2); else n_pass++;
        n_total++; if (HyrjaReady !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", HyrjaReady); else n_pass++;
        tick();
        Resetn = 1'b1;
        // first edge after release behaves as post-reset
        S = 2'd0; Hyrja = 24'h00BEEF; HyrjaValid = 1'b1;
        tick();
        HyrjaValid = 1'b0;
        n_total++; if (DaljaValid !== 4'b0001) $display("FAIL rst_release_valid: got %b want 0001", DaljaValid); else n_pass++;
        n_total++; if (Dalja0 !== 24'h00BEEF) $display("FAIL rst_release_data: got %h want 00beef", Dalja0); else n_pass++;
    endtask

    // ---------------- test: single route and stall ----------------
    task automatic test_single_route();
        do_reset();
        S = 2'd1; Hyrja = 24'hA5A5A5; HyrjaValid = 1'b1;
        #1;
        n_total++; if (HyrjaReady !== 1'b1) $display("FAIL route_ready_empty: got %b want 1", HyrjaReady); else n_pass++;
        tick();
        HyrjaValid = 1'b0;
        n_total++; if (DaljaValid !== 4'b0010) $display("FAIL route_valid: got %b want 0010", DaljaValid); else n_pass++;
        n_total++; if (Dalja1 !== 24'hA5A5A5) $display("FAIL route_data: got %h want a5a5a5", Dalja1); else n_pass++;
        repeat (5) tick();
        n_total++; if (DaljaValid !== 4'b0010) $display("FAIL route_hold_valid: got %b want 0010", DaljaValid); else n_pass++;
        n_total++; if (Dalja1 !== 24'hA5A5A5) $display("FAIL route_hold_data: got %h want a5a5a5", Dalja1); else n_pass++;
        // a second offer to the stalled slot is refused and not latched
        S = 2'd1; Hyrja = 24'h111111; HyrjaValid = 1'b1;
        #1;
        n_total++; if (HyrjaReady !== 1'b0) $display("FAIL route_ready_full: got %b want 0", HyrjaReady); else n_pass++;
        tick(); tick();
        n_total++; if (Dalja1 !== 24'hA5A5A5) $display("FAIL route_no_latch: got %h want a5a5a5", Dalja1); else n_pass++;
        DaljaReady = 4'b0010;
        #1;
        n_total++; if (HyrjaReady !== 1'b1) $display("FAIL route_ready_drain: got %b want 1", HyrjaReady); else n_pass++;
        tick();
        HyrjaValid = 1'b0;
        n_total++; if (Dalja1 !== 24'h111111 || DaljaValid !== 4'b0010) $display("FAIL route_replace: got %h/%b want 111111/0010", Dalja1, DaljaValid); else n_pass++;
        tick();
        n_total++; if (DaljaValid !== 4'b0000) $display("FAIL route_drained: got %b want 0000", DaljaValid); else n_pass++;
        // ready on empty slots is ignored
        DaljaReady = 4'b1111;
        tick();
        n_total++; if (DaljaValid !== 4'b0000) $display("FAIL route_empty_ready: got %b want 0000", DaljaValid); else n_pass++;
        DaljaReady = 4'b0000;
    endtask

    // ---------------- test: pass-through without bubble ----------------
    task automatic test_pass_through();
        do_reset();
        S = 2'd3; Hyrja = 24'h000001; HyrjaValid = 1'b1;
        tick();
        HyrjaValid = 1'b0;
        n_total++; if (Dalja3 !== 24'h000001) $display("FAIL pt_first: got %h want 000001", Dalja3); else n_pass++;
        DaljaReady = 4'b1000;
        S = 2'd3; Hyrja = 24'h000002; HyrjaValid = 1'b1;
        #1;
        n_total++; if (HyrjaReady !== 1'b1) $display("FAIL pt_ready: got %b want 1", HyrjaReady); else n_pass++;
        n_total++; if (Dalja3 !== 24'h000001 || DaljaValid[3] !== 1'b1) $display("FAIL pt_deliver: got %h/%b want 000001/1", Dalja3, DaljaValid[3]); else n_pass++;
        tick();
        HyrjaValid = 1'b0;
        n_total++; if (Dalja3 !== 24'h000002 || DaljaValid[3] !== 1'b1) $display("FAIL pt_load: got %h/%b want 000002/1", Dalja3, DaljaValid[3]); else n_pass++;
        tick();
        n_total++; if (DaljaValid !== 4'b0000) $display("FAIL pt_empty: got %b want 0000", DaljaValid); else n_pass++;
        DaljaReady = 4'b0000;
    endtask

    // ---------------- test: stalled slot does not block others ----------------
    task automatic test_independence();
        logic [W-1:0] k_word;
        do_reset();
        S = 2'd0; Hyrja = 24'h0ABCDE; HyrjaValid = 1'b1;
        tick();
        DaljaReady = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            k_word     = W'(k);
            S          = 2'd2;
            Hyrja      = k_word;
            HyrjaValid = 1'b1;
            #1;
            n_total++; if (HyrjaReady !== 1'b1) $display("FAIL indep_ready[%0d]: got %b want 1", k, HyrjaReady); else n_pass++;
            tick();
            n_total++; if (Dalja2 !== k_word || DaljaValid !== 4'b0101) $display("FAIL indep_word[%0d]: got %h/%b want %h/0101", k, Dalja2, DaljaValid, k_word); else n_pass++;
        end
        HyrjaValid = 1'b0;
        tick();
        n_total++; if (DaljaValid !== 4'b0001) $display("FAIL indep_drain: got %b want 0001", DaljaValid); else n_pass++;
        n_total++; if (Dalja0 !== 24'h0ABCDE) $display("FAIL indep_hold0: got %h want 0abcde", Dalja0); else n_pass++;
        S = 2'd0; HyrjaValid = 1'b1;
        #1;
        n_total++; if (HyrjaReady !== 1'b0) $display("FAIL indep_block0: got %b want 0", HyrjaReady); else n_pass++;
        HyrjaValid = 1'b0;
        DaljaReady = 4'b0000;
    endtask

    // ---------------- test: random back-pressure with scoreboard ----------------
    task automatic test_random();
        logic         blocked;
        logic         exp_ready;
        logic [W-1:0] got;
        logic [W-1:0] want;
        do_reset();
        blocked = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            // producer keeps a refused offer stable until it is taken
            if (!blocked) begin
                S          = 2'($urandom_range(0, 3));
                Hyrja      = W'($urandom);
                HyrjaValid = ($urandom_range(0, 3) != 0);
            end
            DaljaReady = 4'($urandom_range(0, 15));
            #1;
            exp_ready = (exp_q[S].size() == 0) || DaljaReady[S];
            n_total++; if (HyrjaReady !== exp_ready) $display("FAIL rand_ready[%0d]: got %b want %b", c, HyrjaReady, exp_ready); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_total++; if (DaljaValid[i] !== (exp_q[i].size() != 0)) $display("FAIL rand_valid[%0d][%0d]: got %b want %b", c, i, DaljaValid[i], exp_q[i].size() != 0); else n_pass++;
                if (exp_q[i].size() != 0 && DaljaReady[i]) begin
                    want = exp_q[i].pop_front();
                    got  = dalja_of(i);
                    n_total++; if (got !== want) $display("FAIL rand_data[%0d][%0d]: got %h want %h", c, i, got, want); else n_pass++;
                end
            end
            if (HyrjaValid && exp_ready) exp_q[S].push_back(Hyrja);
            blocked = HyrjaValid && !exp_ready;
            tick();
        end
        HyrjaValid = 1'b0;
        DaljaReady = 4'b0000;
    endtask

`ifdef DEMUX1NE4_STATS_EN
    // ---------------- test: saturating transfer counters ----------------
    task automatic test_stats();
        logic [3:0] want;
        do_reset();
        n_total++; if ({Numeruesi0, Numeruesi1, Numeruesi2, Numeruesi3} !== 16'h0) $display("FAIL stats_rst: got %h %h %h %h want 0", Numeruesi0, Numeruesi1, Numeruesi2, Numeruesi3); else n_pass++;
        DaljaReady = 4'b0010;
        S          = 2'd1;
        // offers on edges 0..19, drains on edges 1..20
        for (int j = 0; j <= 20; j++) begin
            HyrjaValid = (j < 20);
            Hyrja      = W'(j + 1);
            tick();
            want = (j > 15) ? 4'd15 : 4'(j);
            n_total++; if (Numeruesi1 !== want) $display("FAIL stats_cnt1[%0d]: got %0d want %0d", j, Numeruesi1, want); else n_pass++;
        end
        n_total++; if ({Numeruesi0, Numeruesi2, Numeruesi3} !== 12'h0) $display("FAIL stats_others: got %h %h %h want 0", Numeruesi0, Numeruesi2, Numeruesi3); else n_pass++;
        n_total++; if (DaljaValid !== 4'b0000) $display("FAIL stats_empty: got %b want 0000", DaljaValid); else n_pass++;
        DaljaReady = 4'b0000;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_route();
        test_pass_through();
        test_independence();
        test_random();
`ifdef DEMUX1NE4_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_demux1ne4_buf
